// File: rtl/partitioned_data_ram.sv
// Partitioned data memory with a per-program context region and a built-in
// context-switch sequencer. Define BOUNDS_CHECK_EN to trap out-of-range accesses.
module partitioned_data_ram #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_PROGRAMS = 5,
    parameter int PART_DEPTH   = 1000,
    parameter int CTX_WORDS    = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            we,
    input  logic [ADDR_WIDTH-1:0]           endereco_leitura,
    input  logic [ADDR_WIDTH-1:0]           endereco_escrita,
    input  logic [DATA_WIDTH-1:0]           data,
    output logic [DATA_WIDTH-1:0]           q,
    input  logic                            switch_req,
    input  logic [ADDR_WIDTH-1:0]           pc_in,
    output logic [ADDR_WIDTH-1:0]           pc_out,
    output logic                            ctx_valid,
    output logic                            busy,
    output logic [$clog2(NUM_PROGRAMS)-1:0] programa,
    output logic                            fault
);
    // state   | meaning
    // IDLE    | normal loads/stores, accepts switch_req
    // SAVE    | outgoing PC written to context word 0
    // ADVANCE | programa steps to the next partition
    // LOAD    | incoming saved PC read into pc_out
    // DONE    | ctx_valid pulse
    localparam int TOTAL  = NUM_PROGRAMS * PART_DEPTH;
    localparam int PHYS_W = $clog2(TOTAL);
    localparam int PROG_W = $clog2(NUM_PROGRAMS);
    localparam int SUM_W  = ((ADDR_WIDTH > PHYS_W) ? ADDR_WIDTH : PHYS_W) + 1;
    localparam int USABLE = PART_DEPTH - CTX_WORDS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_ADVANCE,
        ST_LOAD,
        ST_DONE
    } state_t;

    function automatic logic [PHYS_W-1:0] phys_of(input logic [PROG_W-1:0] prog,
                                                  input logic [ADDR_WIDTH-1:0] rel);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(prog) * SUM_W'(PART_DEPTH) + SUM_W'(CTX_WORDS) + SUM_W'(rel);
        return PHYS_W'(sum % SUM_W'(TOTAL));
    endfunction

    function automatic logic [PHYS_W-1:0] ctx_base(input logic [PROG_W-1:0] prog);
        return PHYS_W'(prog) * PHYS_W'(PART_DEPTH);
    endfunction

    logic [DATA_WIDTH-1:0] mem [TOTAL];

    state_t                state_q, state_d;
    logic [PROG_W-1:0]     programa_q, programa_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
    logic [ADDR_WIDTH-1:0] pc_lat_q, pc_lat_d;
    logic                  ctx_valid_q, ctx_valid_d;
    logic                  busy_q, busy_d;
    logic                  fault_q, fault_d;

    logic                  mem_we;
    logic [PHYS_W-1:0]     mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [PHYS_W-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_oob;
    logic                  wr_oob;

`ifdef BOUNDS_CHECK_EN
    assign rd_oob = endereco_leitura > ADDR_WIDTH'(USABLE - 1);
    assign wr_oob = endereco_escrita > ADDR_WIDTH'(USABLE - 1);
`else
    assign rd_oob = 1'b0;
    assign wr_oob = 1'b0;
`endif

    // One shared read port: the context word in LOAD, the datapath load otherwise.
    assign rd_addr = (state_q == ST_LOAD) ? ctx_base(programa_q)
                                          : phys_of(programa_q, endereco_leitura);
    assign rd_data = mem[rd_addr];

    always_comb begin
        state_d    = state_q;
        programa_d = programa_q;
        q_d        = q_q;
        pc_out_d   = pc_out_q;
        pc_lat_d   = pc_lat_q;
        fault_d    = fault_q;
        mem_we     = 1'b0;
        mem_waddr  = phys_of(programa_q, endereco_escrita);
        mem_wdata  = data;
        case (state_q)
            ST_IDLE: begin
                q_d = rd_oob ? '0 : rd_data;
                if (rd_oob) fault_d = 1'b1;
                if (we) begin
                    if (wr_oob) fault_d = 1'b1;
                    else        mem_we  = 1'b1;
                end
                if (switch_req) begin
                    state_d  = ST_SAVE;
                    pc_lat_d = pc_in;
                end
            end
            ST_SAVE: begin
                mem_we    = 1'b1;
                mem_waddr = ctx_base(programa_q);
                mem_wdata = DATA_WIDTH'(pc_lat_q);
                state_d   = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                programa_d = (programa_q == PROG_W'(NUM_PROGRAMS - 1)) ? '0
                                                                       : programa_q + 1'b1;
                state_d    = ST_LOAD;
            end
            ST_LOAD: begin
                pc_out_d = ADDR_WIDTH'(rd_data);
                state_d  = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d      = (state_d != ST_IDLE);
        ctx_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            programa_q  <= '0;
            q_q         <= '0;
            pc_out_q    <= '0;
            pc_lat_q    <= '0;
            ctx_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            programa_q  <= programa_d;
            q_q         <= q_d;
            pc_out_q    <= pc_out_d;
            pc_lat_q    <= pc_lat_d;
            ctx_valid_q <= ctx_valid_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
        end
    end

    // Storage is deliberately not reset so a saved PC survives an abandoned switch.
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign q         = q_q;
    assign pc_out    = pc_out_q;
    assign ctx_valid = ctx_valid_q;
    assign busy      = busy_q;
    assign programa  = programa_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_partitioned_data_ram.sv
// Directed self-checking bench for partitioned_data_ram (default parameters).
module tb_partitioned_data_ram;
    logic        clock;
    logic        reset;
    logic        we;
    logic [31:0] endereco_leitura;
    logic [31:0] endereco_escrita;
    logic [31:0] data;
    logic [31:0] q;
    logic        switch_req;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic        ctx_valid;
    logic        busy;
    logic [2:0]  programa;
    logic        fault;

    int n_checks = 0;
    int n_err    = 0;

`ifdef BOUNDS_CHECK_EN
    localparam logic [31:0] EXP_FAULT_968 = 32'd1;
    localparam logic [31:0] EXP_Q_968     = 32'd0;
    localparam logic [31:0] EXP_MEM_1000  = 32'h10;
`else
    localparam logic [31:0] EXP_FAULT_968 = 32'd0;
    localparam logic [31:0] EXP_Q_968     = 32'h5A5A;
    localparam logic [31:0] EXP_MEM_1000  = 32'h5A5A;
`endif

    partitioned_data_ram dut (
        .clock            (clock),
        .reset            (reset),
        .we               (we),
        .endereco_leitura (endereco_leitura),
        .endereco_escrita (endereco_escrita),
        .data             (data),
        .q                (q),
        .switch_req       (switch_req),
        .pc_in            (pc_in),
        .pc_out           (pc_out),
        .ctx_valid        (ctx_valid),
        .busy             (busy),
        .programa         (programa),
        .fault            (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one switch; while busy it attempts a store at relative 5 and moves
    // the load address to 0, neither of which may have any effect.
    task automatic do_switch(input logic [31:0] pc, input logic [2:0] exp_prog,
                             input logic chk_pc, input logic [31:0] exp_pc,
                             input logic chk_q, input logic [31:0] exp_q);
        switch_req = 1'b1;
        pc_in      = pc;
        tick();
        switch_req       = 1'b0;
        we               = 1'b1;
        endereco_escrita = 32'd5;
        data             = 32'hBAD0BAD0;
        endereco_leitura = 32'd0;
        check("busy_n1", 32'(busy), 32'd1);
        check("ctxv_n1", 32'(ctx_valid), 32'd0);
        tick();
        check("busy_n2", 32'(busy), 32'd1);
        tick();
        check("busy_n3", 32'(busy), 32'd1);
        check("prog_n3", 32'(programa), 32'(exp_prog));
        tick();
        check("ctxv_n4", 32'(ctx_valid), 32'd1);
        check("busy_n4", 32'(busy), 32'd1);
        if (chk_pc) check("pc_out", pc_out, exp_pc);
        if (chk_q)  check("q_hold", q, exp_q);
        we = 1'b0;
        tick();
        check("busy_n5", 32'(busy), 32'd0);
        check("ctxv_n5", 32'(ctx_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] e_pc [4];
        e_pc = '{32'h200, 32'h300, 32'h400, 32'h500};

        reset = 1'b1; we = 1'b0; switch_req = 1'b0;
        endereco_leitura = '0; endereco_escrita = '0; data = '0; pc_in = '0;
        tick();
        tick();
        check("rst_q", q, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_ctxv", 32'(ctx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_prog", 32'(programa), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        reset = 1'b0;

        // Basic store/load and read-before-write in program 0
        we = 1'b1; endereco_escrita = 32'd5; data = 32'hDEADBEEF; endereco_leitura = 32'd5;
        tick();
        we = 1'b0;
        tick();
        check("load5", q, 32'hDEADBEEF);
        check("mem37", dut.mem[37], 32'hDEADBEEF);
        we = 1'b1; data = 32'h12345678;
        tick();
        check("rbw_old", q, 32'hDEADBEEF);
        we = 1'b0;
        tick();
        check("rbw_new", q, 32'h12345678);

        // Switch away with PC 0x40, then round-trip back to program 0
        do_switch(32'h40, 3'd1, 1'b0, 32'h0, 1'b1, 32'h12345678);
        check("busy_store_blocked", dut.mem[37], 32'h12345678);
        for (int i = 0; i < 4; i++)
            do_switch(32'h10, 3'((i + 2) % 5), (i == 3), 32'h40, 1'b0, 32'h0);

        // Isolation between program 0 and program 1
        we = 1'b1; endereco_escrita = 32'd0; data = 32'h11;
        tick();
        we = 1'b0;
        do_switch(32'h100, 3'd1, 1'b1, 32'h10, 1'b0, 32'h0);
        we = 1'b1; endereco_escrita = 32'd0; data = 32'h22; endereco_leitura = 32'd0;
        tick();
        we = 1'b0;
        tick();
        check("iso_p1", q, 32'h22);
        do_switch(32'h200, 3'd2, 1'b1, 32'h10, 1'b1, 32'h22);
        do_switch(32'h300, 3'd3, 1'b1, 32'h10, 1'b0, 32'h0);
        do_switch(32'h400, 3'd4, 1'b1, 32'h10, 1'b0, 32'h0);
        do_switch(32'h500, 3'd0, 1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        check("iso_p0", q, 32'h11);
        check("mem32", dut.mem[32], 32'h11);
        check("mem1032", dut.mem[1032], 32'h22);

        // Walk to program 4, then wrap through 0..4 and back to 0
        for (int i = 0; i < 4; i++)
            do_switch(32'h10, 3'(i + 1), 1'b1, e_pc[i], 1'b0, 32'h0);
        for (int i = 0; i < 6; i++)
            do_switch(32'h10, 3'(i % 5), 1'b1, 32'h10, 1'b0, 32'h0);
        check("wrap_mem37", dut.mem[37], 32'h12345678);
        check("wrap_mem32", dut.mem[32], 32'h11);
        check("wrap_mem1032", dut.mem[1032], 32'h22);

        // Last usable word and first word past the usable range
        we = 1'b1; endereco_escrita = 32'd967; data = 32'h77; endereco_leitura = 32'd967;
        tick();
        we = 1'b0;
        tick();
        check("load967", q, 32'h77);
        check("mem999", dut.mem[999], 32'h77);
        check("fault_967", 32'(fault), 32'd0);
        we = 1'b1; endereco_escrita = 32'd968; data = 32'h5A5A;
        tick();
        we = 1'b0; endereco_leitura = 32'd968;
        check("fault_968", 32'(fault), EXP_FAULT_968);
        tick();
        check("load968", q, EXP_Q_968);
        check("mem1000", dut.mem[1000], EXP_MEM_1000);

        // Reset while the sequencer sits in LOAD
        endereco_leitura = 32'd967;
        switch_req = 1'b1; pc_in = 32'hAB;
        tick();
        switch_req = 1'b0;
        tick();
        tick();
        check("pre_rst_prog", 32'(programa), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_prog", 32'(programa), 32'd0);
        check("mid_rst_q", q, 32'd0);
        check("mid_rst_pc_out", pc_out, 32'd0);
        check("mid_rst_ctxv", 32'(ctx_valid), 32'd0);
        check("mid_rst_fault", 32'(fault), 32'd0);
        check("saved_pc_kept", dut.mem[0], 32'hAB);
        tick();
        endereco_leitura = 32'd0;
        reset = 1'b0;
        do_switch(32'hCD, 3'd1, 1'b1, EXP_MEM_1000, 1'b0, 32'h0);
        check("post_rst_save", dut.mem[0], 32'hCD);
        check("final_fault", 32'(fault), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
